// File: rtl/bin_to_hex_display_if.sv
// Bus between the counter and the hex display stage: binary value in,
// BCD digits, seven-segment codes and conversion status out.
interface bin_to_hex_display_if #(
  parameter int WIDTH  = 18,
  parameter int DIGITS = 6
);
  logic [WIDTH-1:0]    BIN_IN;
  logic [4*DIGITS-1:0] BCD_OUT;
  logic [6:0]          HEX0;
  logic [6:0]          HEX1;
  logic [6:0]          HEX2;
  logic [6:0]          HEX3;
  logic [6:0]          HEX4;
  logic [6:0]          HEX5;
  logic                BUSY;
  logic                DONE;

  modport master (
    output BIN_IN,
    input  BCD_OUT, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, BUSY, DONE
  );

  modport slave (
    input  BIN_IN,
    output BCD_OUT, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, BUSY, DONE
  );
endinterface

// File: rtl/bin_to_hex_display.sv
// Sequential double-dabble binary-to-BCD converter driving six active-low
// seven-segment displays, reconverting only when the input value changes.
module bin_to_hex_display #(
  parameter int WIDTH         = 18,
  parameter int DIGITS        = 6,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  bin_to_hex_display_if.slave   bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            load_s;
  logic            shift_en_s;
  logic            update_s;

  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] last_value_r;
  logic             last_valid_r;
  logic [BW-1:0]    scratch_r;
  logic [BW-1:0]    scratch_adj_s;
  logic [CW-1:0]    count_r;
  logic [BW-1:0]    bcd_r;
  logic [6:0]       hex_r [6];
  logic [6:0]       seg_s [DIGITS];
  logic             lead_zero_s;
  logic [3:0]       nib_s;
  logic             busy_r;
  logic             done_r;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; count_r==1 means the last shift happens this cycle
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (!last_valid_r || (bus.BIN_IN != last_value_r)) begin
          state_nxt_s = ST_CONV;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (count_r == CW'(1)) begin
          state_nxt_s = ST_UPDATE;
        end else begin
          state_nxt_s = ST_CONV;
        end
      end
      ST_UPDATE: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM control outputs for the datapath
  always_comb begin
    load_s     = 1'b0;
    shift_en_s = 1'b0;
    update_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (state_nxt_s == ST_CONV) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_CONV:   shift_en_s = 1'b1;
      ST_UPDATE: update_s   = 1'b1;
      default: begin
        load_s     = 1'b0;
        shift_en_s = 1'b0;
        update_s   = 1'b0;
      end
    endcase
  end

  // Add-3 correction applied to every BCD nibble before each shift
  always_comb begin
    scratch_adj_s = scratch_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_r[4*i +: 4] >= 4'd5) begin
        scratch_adj_s[4*i +: 4] = scratch_r[4*i +: 4] + 4'd3;
      end else begin
        scratch_adj_s[4*i +: 4] = scratch_r[4*i +: 4];
      end
    end
  end

  // Segment encoding with leading-zero blanking, scanned from the top digit down
  always_comb begin
    lead_zero_s = 1'b1;
    nib_s       = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib_s       = scratch_r[4*i +: 4];
      lead_zero_s = lead_zero_s && (nib_s == 4'd0);
      if ((BLANK_LEADING != 0) && (i != 0) && lead_zero_s) begin
        seg_s[i] = 7'h7F;
      end else begin
        seg_s[i] = seg_encode(nib_s);
      end
    end
  end

  // Conversion datapath and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      shift_r      <= {WIDTH{1'b0}};
      last_value_r <= {WIDTH{1'b0}};
      last_valid_r <= 1'b0;
      scratch_r    <= {BW{1'b0}};
      count_r      <= {CW{1'b0}};
      bcd_r        <= {BW{1'b0}};
      for (int i = 0; i < 6; i++) begin
        hex_r[i] <= 7'h7F;
      end
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      if (load_s) begin
        shift_r      <= bus.BIN_IN;
        last_value_r <= bus.BIN_IN;
        last_valid_r <= 1'b1;
        scratch_r    <= {BW{1'b0}};
        count_r      <= CW'(WIDTH);
      end else if (shift_en_s) begin
        {scratch_r, shift_r} <= {scratch_adj_s, shift_r} << 1;
        count_r              <= count_r - CW'(1);
      end else begin
        count_r <= count_r;
      end
      if (update_s) begin
        bcd_r <= scratch_r;
        for (int i = 0; i < 6; i++) begin
          hex_r[i] <= seg_s[i];
        end
      end else begin
        bcd_r <= bcd_r;
      end
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= update_s;
    end
  end

  assign bus.BCD_OUT = bcd_r;
  assign bus.HEX0    = hex_r[0];
  assign bus.HEX1    = hex_r[1];
  assign bus.HEX2    = hex_r[2];
  assign bus.HEX3    = hex_r[3];
  assign bus.HEX4    = hex_r[4];
  assign bus.HEX5    = hex_r[5];
  assign bus.BUSY    = busy_r;
  assign bus.DONE    = done_r;

endmodule

// File: tb/tb_bin_to_hex_display.sv
// Scoreboard bench for bin_to_hex_display: one DUT with leading-zero blanking,
// one without; expected BCD/segments come from a decimal reference model.
module tb_bin_to_hex_display;

  logic CLOCK_50 = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [23:0] bcd;
    logic [41:0] hex;
  } exp_t;

  exp_t sb_q[$];

  always #10 CLOCK_50 = ~CLOCK_50;

  bin_to_hex_display_if #(.WIDTH(18), .DIGITS(6)) bus_b ();
  bin_to_hex_display_if #(.WIDTH(18), .DIGITS(6)) bus_n ();

  bin_to_hex_display #(.WIDTH(18), .DIGITS(6), .BLANK_LEADING(1)) dut_blank (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .bus      (bus_b)
  );

  bin_to_hex_display #(.WIDTH(18), .DIGITS(6), .BLANK_LEADING(0)) dut_full (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .bus      (bus_n)
  );

  logic [41:0] hex_b;
  logic [41:0] hex_n;
  assign hex_b = {bus_b.HEX5, bus_b.HEX4, bus_b.HEX3, bus_b.HEX2, bus_b.HEX1, bus_b.HEX0};
  assign hex_n = {bus_n.HEX5, bus_n.HEX4, bus_n.HEX3, bus_n.HEX2, bus_n.HEX1, bus_n.HEX0};

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Decimal reference: digits by repeated division, blanking scanned from the top
  function automatic exp_t model(input int v, input bit blank);
    exp_t e;
    int   d[6];
    int   r;
    bit   lead;
    r = v;
    for (int i = 0; i < 6; i++) begin
      d[i] = r % 10;
      r    = r / 10;
      e.bcd[4*i +: 4] = 4'(d[i]);
    end
    lead = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      lead = lead && (d[i] == 0);
      e.hex[7*i +: 7] = (blank && (i != 0) && lead) ? 7'h7F : seg_of(d[i]);
    end
    return e;
  endfunction

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Advance until DONE from the selected DUT (bounded); counts cycles with BUSY low
  task automatic wait_done(input bit full, output int n, output int busy_low);
    n = 0;
    busy_low = 0;
    while (n < 200) begin
      step();
      n++;
      if (full ? bus_n.DONE : bus_b.DONE) break;
      if (!(full ? bus_n.BUSY : bus_b.BUSY)) busy_low++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus_b.BIN_IN = 18'd0;
    bus_n.BIN_IN = 18'd0;
    repeat (3) step();
    checks++;
    if (bus_b.BCD_OUT !== 24'h000000) begin
      errors++; $display("FAIL reset_bcd: got %h expected 000000", bus_b.BCD_OUT);
    end
    checks++;
    if (hex_b !== {6{7'h7F}}) begin
      errors++; $display("FAIL reset_hex: got %h expected %h", hex_b, {6{7'h7F}});
    end
    checks++;
    if (bus_b.BUSY !== 1'b0 || bus_b.DONE !== 1'b0) begin
      errors++; $display("FAIL reset_status: got busy=%b done=%b expected 0 0", bus_b.BUSY, bus_b.DONE);
    end
    checks++;
    if (hex_n !== {6{7'h7F}}) begin
      errors++; $display("FAIL reset_hex_full: got %h expected %h", hex_n, {6{7'h7F}});
    end
  endtask

  task automatic test_first_conversion();
    int   n;
    int   busy_low;
    int   extra_done;
    exp_t e;
    sb_q.push_back(model(0, 1'b1));
    RESET = 1'b0;
    step();
    checks++;
    if (bus_b.BUSY !== 1'b1) begin
      errors++; $display("FAIL first_busy_start: got %b expected 1", bus_b.BUSY);
    end
    wait_done(1'b0, n, busy_low);
    checks++;
    if (n != 19) begin
      errors++; $display("FAIL first_latency: got %0d cycles expected 19", n);
    end
    checks++;
    if (busy_low != 0 || bus_b.BUSY !== 1'b0) begin
      errors++; $display("FAIL first_busy: got %0d low cycles, busy at done %b expected 0 0", busy_low, bus_b.BUSY);
    end
    e = sb_q.pop_front();
    checks++;
    if (bus_b.BCD_OUT !== e.bcd) begin
      errors++; $display("FAIL first_bcd: got %h expected %h", bus_b.BCD_OUT, e.bcd);
    end
    checks++;
    if (hex_b !== e.hex) begin
      errors++; $display("FAIL first_hex: got %h expected %h", hex_b, e.hex);
    end
    extra_done = 0;
    repeat (30) begin
      step();
      if (bus_b.DONE || bus_b.BUSY) extra_done++;
    end
    checks++;
    if (extra_done != 0) begin
      errors++; $display("FAIL idle_no_redo: got %0d active cycles expected 0", extra_done);
    end
  endtask

  task automatic test_values();
    int   vals[7] = '{262143, 0, 262143, 99999, 100000, 1, 10};
    int   n;
    int   busy_low;
    exp_t e;
    foreach (vals[k]) begin
      bus_b.BIN_IN = 18'(vals[k]);
      sb_q.push_back(model(vals[k], 1'b1));
      step();
      wait_done(1'b0, n, busy_low);
      checks++;
      if (n != 19 || busy_low != 0) begin
        errors++; $display("FAIL value_latency %0d: got %0d cycles busy_low=%0d expected 19 0", vals[k], n, busy_low);
      end
      if (sb_q.size() == 0) begin
        checks++; errors++; $display("FAIL value_queue %0d: got empty expected entry", vals[k]);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (bus_b.BCD_OUT !== e.bcd) begin
          errors++; $display("FAIL value_bcd %0d: got %h expected %h", vals[k], bus_b.BCD_OUT, e.bcd);
        end
        checks++;
        if (hex_b !== e.hex) begin
          errors++; $display("FAIL value_hex %0d: got %h expected %h", vals[k], hex_b, e.hex);
        end
      end
    end
  endtask

  task automatic test_no_blanking();
    int   n;
    int   busy_low;
    exp_t e;
    bus_n.BIN_IN = 18'd123;
    sb_q.push_back(model(123, 1'b0));
    step();
    wait_done(1'b1, n, busy_low);
    e = sb_q.pop_front();
    checks++;
    if (n != 19) begin
      errors++; $display("FAIL noblank_latency: got %0d expected 19", n);
    end
    checks++;
    if (bus_n.BCD_OUT !== e.bcd) begin
      errors++; $display("FAIL noblank_bcd: got %h expected %h", bus_n.BCD_OUT, e.bcd);
    end
    checks++;
    if (hex_n !== e.hex) begin
      errors++; $display("FAIL noblank_hex: got %h expected %h", hex_n, e.hex);
    end
  endtask

  task automatic test_change_during_conv();
    int   n;
    int   busy_low;
    exp_t e;
    bus_b.BIN_IN = 18'd5;
    sb_q.push_back(model(5, 1'b1));
    sb_q.push_back(model(77, 1'b1));
    step();
    repeat (4) step();
    bus_b.BIN_IN = 18'd77;
    wait_done(1'b0, n, busy_low);
    e = sb_q.pop_front();
    checks++;
    if (n != 15 || bus_b.BCD_OUT !== e.bcd) begin
      errors++; $display("FAIL midchange_first: got %0d cycles bcd %h expected 15 %h", n, bus_b.BCD_OUT, e.bcd);
    end
    wait_done(1'b0, n, busy_low);
    e = sb_q.pop_front();
    checks++;
    if (n != 20 || bus_b.BCD_OUT !== e.bcd) begin
      errors++; $display("FAIL midchange_second: got %0d cycles bcd %h expected 20 %h", n, bus_b.BCD_OUT, e.bcd);
    end
    checks++;
    if (hex_b !== e.hex) begin
      errors++; $display("FAIL midchange_hex: got %h expected %h", hex_b, e.hex);
    end
  endtask

  task automatic test_reset_mid_conv();
    int   n;
    int   busy_low;
    int   dones;
    exp_t e;
    bus_b.BIN_IN = 18'd4321;
    step();
    dones = 0;
    repeat (10) begin
      step();
      if (bus_b.DONE) dones++;
    end
    RESET = 1'b1;
    step();
    if (bus_b.DONE) dones++;
    checks++;
    if (bus_b.BCD_OUT !== 24'h000000 || hex_b !== {6{7'h7F}}) begin
      errors++; $display("FAIL midreset_out: got bcd %h hex %h expected 000000 %h", bus_b.BCD_OUT, hex_b, {6{7'h7F}});
    end
    checks++;
    if (bus_b.BUSY !== 1'b0 || dones != 0) begin
      errors++; $display("FAIL midreset_status: got busy=%b dones=%0d expected 0 0", bus_b.BUSY, dones);
    end
    step();
    RESET = 1'b0;
    sb_q.push_back(model(4321, 1'b1));
    wait_done(1'b0, n, busy_low);
    e = sb_q.pop_front();
    checks++;
    if (n != 20) begin
      errors++; $display("FAIL midreset_latency: got %0d expected 20", n);
    end
    checks++;
    if (bus_b.BCD_OUT !== e.bcd || hex_b !== e.hex) begin
      errors++; $display("FAIL midreset_value: got %h/%h expected %h/%h", bus_b.BCD_OUT, hex_b, e.bcd, e.hex);
    end
  endtask

  initial begin
    test_reset();
    test_first_conversion();
    test_values();
    test_no_blanking();
    test_change_during_conv();
    test_reset_mid_conv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
